pulse_sequencer: RTL and testbench
==================================

# pulse_sequencer

Clocked sequencer that replaces the free-running analog pulse source with a programmable, cycle-accurate trapezoid envelope: delay, rise, high, fall, low, repeated per period. Emits an amplitude code for the downstream DAC/current-source stage. Takes timing and amplitude words through a valid/ready configuration port and applies new settings only at a period boundary, so the waveform never glitches mid-period.

## Interface
- TW, 16, width of every timing field (cycles)
- AW, 12, width of amplitude, step and level codes
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  one-cycle pulse; begin sequencing from IDLE
- stop  in  1  one-cycle pulse; end sequencing at next period boundary
- cfg_valid  in  1  configuration word valid
- cfg_ready  out  1  shadow register empty; reset 1
- cfg_td, cfg_tr, cfg_th, cfg_tf, cfg_tl  in  TW each  delay/rise/high/fall/low lengths in cycles
- cfg_amp  in  AW  plateau level
- cfg_rstep, cfg_fstep  in  AW each  per-cycle rise/fall increment
- level  out  AW  envelope code; reset 0
- phase  out  3  0 IDLE, 1 DELAY, 2 RISE, 3 HIGH, 4 FALL, 5 LOW, 6 DONE; reset 0
- busy  out  1  phase not IDLE/DONE; reset 0
- period_strobe  out  1  one-cycle pulse on the last LOW cycle; reset 0

## Operation
- Two register sets: active (drives sequencing) and shadow (one entry). Transfer cfg_valid && cfg_ready writes shadow, drops cfg_ready.
- Shadow → active copy: in IDLE/DONE on the cycle after the transfer; when running, on the cycle period_strobe is high. Copy re-raises cfg_ready. Transfer and copy in the same cycle: copy uses previous shadow, new word captured, cfg_ready stays 0.
- Phase length N cycles exactly; N=0 skips that phase. If tr=th=tf=tl=0, th is treated as 1.
- DELAY runs once per start; periods loop RISE→HIGH→FALL→LOW→RISE.
- level: DELAY/LOW/IDLE/DONE 0; RISE cycle j (1-based) = min(amp, j·rstep); HIGH = amp; FALL cycle j = max(0, amp − j·fstep). Arithmetic AW+1 bits, saturating, no wrap.
- start in IDLE/DONE: enter first nonzero phase of DELAY,RISE,HIGH,FALL,LOW. start while running ignored.
- stop while running: latched; at period boundary go to IDLE, level 0. stop in IDLE ignored. start and stop same cycle in IDLE: start wins, stop dropped.
- rst: all outputs to reset values, shadow cleared, pending stop cleared, regardless of phase.

## Timing
- start sampled at edge k → phase/level of first phase visible after edge k.
- Phase of length N occupies edges k..k+N−1; next phase visible after edge k+N.
- Period = tr+th+tf+tl cycles (with the all-zero rule). period_strobe coincides with last LOW cycle (last nonzero phase if tl=0).
- New active config affects the first cycle after the strobe cycle.
- cfg_ready returns high one cycle after copy-enable.

## Configuration
- PULSE_SEQ_BURST_EN defined: extra input cfg_bursts (TW, 0 = infinite) in the config word; period counter increments per period_strobe; on reaching cfg_bursts go to DONE (phase 6, level 0, busy 0) until next start or rst. start from DONE restarts with DELAY and clears the counter.
- Undefined: no cfg_bursts port, DONE never entered; sequencing runs until stop.

## Test plan
- Reset mid-HIGH (amp=0x800) → next cycle level 0, phase 0, busy 0, cfg_ready 1.
- td=3,tr=4,th=2,tf=4,tl=2,amp=0x400,rstep=fstep=0x100, start → 3×0, then 0x100,0x200,0x300,0x400, 0x400×2, 0x300,0x200,0x100,0x000, 0×2; strobe at cycle 15; repeats without delay.
- rstep=0x300, amp=0x400, tr=3 → rise levels 0x300,0x400,0x400 (saturation).
- New config (amp=0x200) pushed mid-RISE → cfg_ready 0 until strobe; next period plateau 0x200, current period unchanged.
- tr=th=tf=tl=0 → level=amp every cycle, strobe every cycle; stop → IDLE after one cycle.
- PULSE_SEQ_BURST_EN, cfg_bursts=2 → exactly two strobes, then phase 6, busy 0; start → DELAY again.

Source files
------------

// File: rtl/pulse_sequencer.sv
// pulse_sequencer
//   Programmable trapezoid envelope generator. After a start pulse it plays
//   DELAY once, then loops RISE -> HIGH -> FALL -> LOW, producing an amplitude
//   code per cycle for the downstream DAC / current-source stage.
//   Configuration arrives through a one-entry shadow register (valid/ready)
//   and is copied into the active set only while idle or on the last cycle of
//   a period, so a period in flight never changes shape.
//
// Optional feature (compile-time macro PULSE_SEQ_BURST_EN):
//   adds input cfg_bursts. After that many periods the sequencer parks in
//   DONE (phase 6). cfg_bursts = 0 means run until stop.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   start, stop         one-cycle control pulses
//   cfg_valid/cfg_ready configuration handshake
//   cfg_td..cfg_tl      phase lengths in cycles (0 skips the phase)
//   cfg_amp             plateau level
//   cfg_rstep/cfg_fstep per-cycle rise / fall increments
//   cfg_bursts          period count before DONE (burst build only)
//   level               envelope code
//   phase               0 IDLE,1 DELAY,2 RISE,3 HIGH,4 FALL,5 LOW,6 DONE
//   busy                phase is DELAY..LOW
//   period_strobe       high on the last cycle of every period
//
// Handshake: a configuration word is taken on any rising edge where
//   cfg_valid && cfg_ready; cfg_valid may be held or dropped freely while
//   cfg_ready is low, and the word is ignored in that case.
module pulse_sequencer #(
  parameter int TW = 16,
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stop,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [TW-1:0] cfg_td,
  input  logic [TW-1:0] cfg_tr,
  input  logic [TW-1:0] cfg_th,
  input  logic [TW-1:0] cfg_tf,
  input  logic [TW-1:0] cfg_tl,
`ifdef PULSE_SEQ_BURST_EN
  input  logic [TW-1:0] cfg_bursts,
`endif
  input  logic [AW-1:0] cfg_amp,
  input  logic [AW-1:0] cfg_rstep,
  input  logic [AW-1:0] cfg_fstep,
  output logic [AW-1:0] level,
  output logic [2:0]    phase,
  output logic          busy,
  output logic          period_strobe
);

  localparam logic [2:0] PH_IDLE  = 3'd0;
  localparam logic [2:0] PH_DELAY = 3'd1;
  localparam logic [2:0] PH_RISE  = 3'd2;
  localparam logic [2:0] PH_HIGH  = 3'd3;
  localparam logic [2:0] PH_FALL  = 3'd4;
  localparam logic [2:0] PH_LOW   = 3'd5;
  localparam logic [2:0] PH_DONE  = 3'd6;

  typedef struct packed {
    logic [TW-1:0] td;
    logic [TW-1:0] tr;
    logic [TW-1:0] th;
    logic [TW-1:0] tf;
    logic [TW-1:0] tl;
`ifdef PULSE_SEQ_BURST_EN
    logic [TW-1:0] bursts;
`endif
    logic [AW-1:0] amp;
    logic [AW-1:0] rstep;
    logic [AW-1:0] fstep;
  } cfg_t;

  // Length of a phase; an all-zero loop collapses to a one-cycle HIGH so the
  // period is never empty.
  function automatic logic [TW-1:0] phase_len(input logic [2:0] p, input cfg_t c);
    logic all_zero;
    all_zero = (c.tr == '0) && (c.th == '0) && (c.tf == '0) && (c.tl == '0);
    case (p)
      PH_DELAY: phase_len = c.td;
      PH_RISE:  phase_len = c.tr;
      PH_HIGH:  phase_len = all_zero ? TW'(1) : c.th;
      PH_FALL:  phase_len = c.tf;
      PH_LOW:   phase_len = c.tl;
      default:  phase_len = '0;
    endcase
  endfunction

  // First loop phase at or after p with a nonzero length.
  function automatic logic [2:0] first_loop_from(input logic [2:0] p, input cfg_t c);
    first_loop_from = PH_LOW;
    for (int i = 5; i >= 2; i--) begin
      if ((3'(i) >= p) && (phase_len(3'(i), c) != '0)) first_loop_from = 3'(i);
    end
  endfunction

  // True when every loop phase after p is skipped, i.e. p closes the period.
  function automatic logic is_last(input logic [2:0] p, input cfg_t c);
    is_last = 1'b1;
    for (int i = 2; i <= 5; i++) begin
      if ((3'(i) > p) && (phase_len(3'(i), c) != '0)) is_last = 1'b0;
    end
  endfunction

  // Saturating helpers: one extra bit catches overflow / borrow.
  function automatic logic [AW-1:0] sat_add(input logic [AW-1:0] a, input logic [AW-1:0] b,
                                            input logic [AW-1:0] cap);
    logic [AW:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    sat_add = (sum > {1'b0, cap}) ? cap : sum[AW-1:0];
  endfunction

  function automatic logic [AW-1:0] sat_sub(input logic [AW-1:0] a, input logic [AW-1:0] b);
    logic [AW:0] diff;
    diff = {1'b0, a} - {1'b0, b};
    sat_sub = diff[AW] ? '0 : diff[AW-1:0];
  endfunction

  // Level on the first cycle of a phase (RISE j=1, FALL j=1).
  function automatic logic [AW-1:0] entry_level(input logic [2:0] p, input cfg_t c);
    case (p)
      PH_RISE: entry_level = sat_add('0, c.rstep, c.amp);
      PH_HIGH: entry_level = c.amp;
      PH_FALL: entry_level = sat_sub(c.amp, c.fstep);
      default: entry_level = '0;
    endcase
  endfunction

  logic [2:0]    phase_q, phase_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] level_q, level_d;
  logic          stop_pend_q, stop_pend_d;
  logic          shadow_full_q, shadow_full_d;
  cfg_t          active_q, active_d;
  cfg_t          shadow_q, shadow_d;
`ifdef PULSE_SEQ_BURST_EN
  logic [TW-1:0] burst_cnt_q, burst_cnt_d;
`endif

  cfg_t          cfg_in;
  cfg_t          cfg_n;
  logic          cfg_xfer;
  logic          copy_en;
  logic          loop_phase;
  logic          phase_end;
  logic          burst_hit;
  logic [2:0]    nxt;

  always_comb begin
    cfg_in.td    = cfg_td;
    cfg_in.tr    = cfg_tr;
    cfg_in.th    = cfg_th;
    cfg_in.tf    = cfg_tf;
    cfg_in.tl    = cfg_tl;
`ifdef PULSE_SEQ_BURST_EN
    cfg_in.bursts = cfg_bursts;
`endif
    cfg_in.amp   = cfg_amp;
    cfg_in.rstep = cfg_rstep;
    cfg_in.fstep = cfg_fstep;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q       <= PH_IDLE;
      cnt_q         <= '0;
      level_q       <= '0;
      stop_pend_q   <= 1'b0;
      shadow_full_q <= 1'b0;
      active_q      <= '0;
      shadow_q      <= '0;
`ifdef PULSE_SEQ_BURST_EN
      burst_cnt_q   <= '0;
`endif
    end else begin
      phase_q       <= phase_d;
      cnt_q         <= cnt_d;
      level_q       <= level_d;
      stop_pend_q   <= stop_pend_d;
      shadow_full_q <= shadow_full_d;
      active_q      <= active_d;
      shadow_q      <= shadow_d;
`ifdef PULSE_SEQ_BURST_EN
      burst_cnt_q   <= burst_cnt_d;
`endif
    end
  end

  // Next-state logic. Transitions out of the strobe cycle (and out of
  // IDLE/DONE) see the configuration that is being copied this cycle, so a
  // new word takes effect on the very next cycle.
  always_comb begin
    cfg_n         = copy_en ? shadow_q : active_q;
    active_d      = cfg_n;
    shadow_d      = cfg_xfer ? cfg_in : shadow_q;
    shadow_full_d = cfg_xfer | (shadow_full_q & ~copy_en);
    phase_d       = phase_q;
    cnt_d         = cnt_q;
    level_d       = level_q;
    stop_pend_d   = stop_pend_q | (busy & stop);
    burst_hit     = 1'b0;
    nxt           = PH_IDLE;
`ifdef PULSE_SEQ_BURST_EN
    burst_cnt_d   = burst_cnt_q;
`endif
    case (phase_q)
      PH_IDLE, PH_DONE: begin
        // start wins over a simultaneous stop, which is simply dropped.
        if (start) begin
          stop_pend_d = 1'b0;
          cnt_d       = '0;
`ifdef PULSE_SEQ_BURST_EN
          burst_cnt_d = '0;
`endif
          nxt         = (cfg_n.td != '0) ? PH_DELAY : first_loop_from(PH_RISE, cfg_n);
          phase_d     = nxt;
          level_d     = entry_level(nxt, cfg_n);
        end
      end
      PH_DELAY: begin
        if (phase_end) begin
          cnt_d   = '0;
          nxt     = first_loop_from(PH_RISE, active_q);
          phase_d = nxt;
          level_d = entry_level(nxt, active_q);
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      PH_RISE, PH_HIGH, PH_FALL, PH_LOW: begin
        if (phase_end) begin
          cnt_d = '0;
          if (period_strobe) begin
`ifdef PULSE_SEQ_BURST_EN
            burst_cnt_d = burst_cnt_q + TW'(1);
            burst_hit   = (active_q.bursts != '0) && (burst_cnt_d == active_q.bursts);
`endif
            if (stop_pend_q | stop) begin
              phase_d     = PH_IDLE;
              level_d     = '0;
              stop_pend_d = 1'b0;
            end else if (burst_hit) begin
              phase_d     = PH_DONE;
              level_d     = '0;
            end else begin
              nxt     = first_loop_from(PH_RISE, cfg_n);
              phase_d = nxt;
              level_d = entry_level(nxt, cfg_n);
            end
          end else begin
            nxt     = first_loop_from(phase_q + 3'd1, active_q);
            phase_d = nxt;
            level_d = entry_level(nxt, active_q);
          end
        end else begin
          cnt_d = cnt_q + TW'(1);
          if (phase_q == PH_RISE) level_d = sat_add(level_q, active_q.rstep, active_q.amp);
          else if (phase_q == PH_FALL) level_d = sat_sub(level_q, active_q.fstep);
        end
      end
      default: begin
        phase_d = PH_IDLE;
        cnt_d   = '0;
        level_d = '0;
      end
    endcase
  end

  // Outputs and per-cycle status decodes.
  always_comb begin
    phase         = phase_q;
    level         = level_q;
    cfg_ready     = ~shadow_full_q;
    cfg_xfer      = cfg_valid & ~shadow_full_q;
    busy          = (phase_q >= PH_DELAY) && (phase_q <= PH_LOW);
    loop_phase    = (phase_q >= PH_RISE) && (phase_q <= PH_LOW);
    phase_end     = (cnt_q == (phase_len(phase_q, active_q) - TW'(1)));
    period_strobe = loop_phase && phase_end && is_last(phase_q, active_q);
    copy_en       = shadow_full_q &&
                    ((phase_q == PH_IDLE) || (phase_q == PH_DONE) || period_strobe);
  end

endmodule

// File: tb/tb_pulse_sequencer.sv
// Self-checking bench for pulse_sequencer. Driver tasks push the expected
// per-cycle outputs into exp_q; a negedge monitor pops and compares.
module tb_pulse_sequencer;
  localparam int TW = 16;
  localparam int AW = 12;
  localparam int EW = 3 + AW + 3;

  logic          clk;
  logic          rst;
  logic          start;
  logic          stop;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [TW-1:0] cfg_td, cfg_tr, cfg_th, cfg_tf, cfg_tl;
`ifdef PULSE_SEQ_BURST_EN
  logic [TW-1:0] cfg_bursts;
`endif
  logic [AW-1:0] cfg_amp, cfg_rstep, cfg_fstep;
  logic [AW-1:0] level;
  logic [2:0]    phase;
  logic          busy;
  logic          period_strobe;

  pulse_sequencer #(.TW(TW), .AW(AW)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .stop          (stop),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .cfg_td        (cfg_td),
    .cfg_tr        (cfg_tr),
    .cfg_th        (cfg_th),
    .cfg_tf        (cfg_tf),
    .cfg_tl        (cfg_tl),
`ifdef PULSE_SEQ_BURST_EN
    .cfg_bursts    (cfg_bursts),
`endif
    .cfg_amp       (cfg_amp),
    .cfg_rstep     (cfg_rstep),
    .cfg_fstep     (cfg_fstep),
    .level         (level),
    .phase         (phase),
    .busy          (busy),
    .period_strobe (period_strobe)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  // Entry layout: {phase, level, period_strobe, busy, cfg_ready}
  logic [EW-1:0] exp_q[$];
  string         tag_q[$];
  int            checks = 0;
  int            errors = 0;

  always @(negedge clk) begin
    logic [EW-1:0] e;
    logic [EW-1:0] got;
    string         t;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      t   = tag_q.pop_front();
      got = {phase, level, period_strobe, busy, cfg_ready};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL %s: got ph=%0d lvl=%h stb=%b busy=%b rdy=%b, exp ph=%0d lvl=%h stb=%b busy=%b rdy=%b",
                 t, got[EW-1 -: 3], got[AW+2:3], got[2], got[1], got[0],
                 e[EW-1 -: 3], e[AW+2:3], e[2], e[1], e[0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Advance one edge (inputs already set) and record the outputs expected
  // for the cycle that follows it.
  task automatic cyc(input string tag, input logic [2:0] ph, input logic [AW-1:0] lv,
                     input logic stb, input logic rdy);
    @(posedge clk);
    #1;
    exp_q.push_back({ph, lv, stb, (ph >= 3'd1) && (ph <= 3'd5), rdy});
    tag_q.push_back(tag);
  endtask

  task automatic set_cfg(input int td, input int tr, input int th, input int tf, input int tl,
                         input int amp, input int rs, input int fs, input int bursts);
    cfg_td    = TW'(td);
    cfg_tr    = TW'(tr);
    cfg_th    = TW'(th);
    cfg_tf    = TW'(tf);
    cfg_tl    = TW'(tl);
    cfg_amp   = AW'(amp);
    cfg_rstep = AW'(rs);
    cfg_fstep = AW'(fs);
`ifdef PULSE_SEQ_BURST_EN
    cfg_bursts = TW'(bursts);
`else
    if (bursts != 0) $display("note: burst count ignored in this build");
`endif
  endtask

  // Load a word while idle: one edge to fill the shadow, one to copy it.
  task automatic load_cfg(input int td, input int tr, input int th, input int tf, input int tl,
                          input int amp, input int rs, input int fs, input int bursts);
    set_cfg(td, tr, th, tf, tl, amp, rs, fs, bursts);
    cfg_valid = 1'b1;
    cyc("cfg_xfer", 3'd0, '0, 1'b0, 1'b0);
    cfg_valid = 1'b0;
    cyc("cfg_copy", 3'd0, '0, 1'b0, 1'b1);
  endtask

  // Plays one loop period from a small envelope model. do_start pulses start
  // on the first edge; push_idx issues cfg_valid on that edge; stop_idx raises
  // stop during that entry's cycle.
  task automatic run_period(input string tag, input int tr, input int th, input int tf,
                            input int tl, input int amp, input int rs, input int fs,
                            input bit do_start, input bit rdy_in, input int push_idx,
                            input int stop_idx);
    int ph_q[$];
    int lv_q[$];
    int thx;
    bit rdy;
    thx = (tr == 0 && th == 0 && tf == 0 && tl == 0) ? 1 : th;
    for (int j = 1; j <= tr; j++) begin
      ph_q.push_back(2);
      lv_q.push_back((j * rs > amp) ? amp : j * rs);
    end
    for (int j = 1; j <= thx; j++) begin
      ph_q.push_back(3);
      lv_q.push_back(amp);
    end
    for (int j = 1; j <= tf; j++) begin
      ph_q.push_back(4);
      lv_q.push_back((j * fs >= amp) ? 0 : amp - j * fs);
    end
    for (int j = 1; j <= tl; j++) begin
      ph_q.push_back(5);
      lv_q.push_back(0);
    end
    rdy = rdy_in;
    for (int i = 0; i < ph_q.size(); i++) begin
      start     = do_start && (i == 0);
      cfg_valid = (i == push_idx);
      if (i == push_idx) rdy = 1'b0;
      cyc(tag, 3'(ph_q[i]), AW'(lv_q[i]), i == ph_q.size() - 1, rdy);
      start     = 1'b0;
      cfg_valid = 1'b0;
      stop      = 1'b0;
      if (i == stop_idx) stop = 1'b1;
    end
  endtask

  // Hand-computed first period for td=3,tr=4,th=2,tf=4,tl=2,amp=0x400,step 0x100.
  logic [2:0]    b_ph [12] = '{3'd2, 3'd2, 3'd2, 3'd2, 3'd3, 3'd3,
                               3'd4, 3'd4, 3'd4, 3'd4, 3'd5, 3'd5};
  logic [AW-1:0] b_lv [12] = '{12'h100, 12'h200, 12'h300, 12'h400, 12'h400, 12'h400,
                               12'h300, 12'h200, 12'h100, 12'h000, 12'h000, 12'h000};

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; cfg_valid = 1'b0;
    set_cfg(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset state
    cyc("reset", 3'd0, '0, 1'b0, 1'b1);
    rst = 1'b0;
    cyc("idle", 3'd0, '0, 1'b0, 1'b1);

    // Main trapezoid with delay; second period has no delay, stop ends it
    load_cfg(3, 4, 2, 4, 2, 'h400, 'h100, 'h100, 0);
    start = 1'b1;
    cyc("b_delay", 3'd1, '0, 1'b0, 1'b1);
    start = 1'b0;
    cyc("b_delay", 3'd1, '0, 1'b0, 1'b1);
    cyc("b_delay", 3'd1, '0, 1'b0, 1'b1);
    for (int i = 0; i < 12; i++) cyc("b_p1", b_ph[i], b_lv[i], i == 11, 1'b1);
    run_period("b_p2", 4, 2, 4, 2, 'h400, 'h100, 'h100, 1'b0, 1'b1, -1, 3);
    cyc("b_stop", 3'd0, '0, 1'b0, 1'b1);
    stop = 1'b0;

    // Saturating rise and fall; stop raised in the strobe cycle itself
    load_cfg(0, 3, 1, 2, 1, 'h400, 'h300, 'h300, 0);
    run_period("c_sat", 3, 1, 2, 1, 'h400, 'h300, 'h300, 1'b1, 1'b1, -1, 6);
    cyc("c_stop", 3'd0, '0, 1'b0, 1'b1);
    stop = 1'b0;

    // stop while idle is ignored
    stop = 1'b1;
    cyc("idle_stop", 3'd0, '0, 1'b0, 1'b1);
    stop = 1'b0;

    // Config pushed mid-RISE; start+stop together (start wins)
    load_cfg(0, 4, 2, 4, 2, 'h400, 'h100, 'h100, 0);
    set_cfg(0, 4, 2, 4, 2, 'h200, 'h100, 'h100, 0);
    stop = 1'b1;
    run_period("d_old", 4, 2, 4, 2, 'h400, 'h100, 'h100, 1'b1, 1'b1, 1, -1);
    run_period("d_new", 4, 2, 4, 2, 'h200, 'h100, 'h100, 1'b0, 1'b1, -1, 11);
    cyc("d_stop", 3'd0, '0, 1'b0, 1'b1);
    stop = 1'b0;

    // All-zero timing: one-cycle HIGH period, strobe every cycle
    load_cfg(0, 0, 0, 0, 0, 'h5a5, 'h111, 'h111, 0);
    run_period("e_zero0", 0, 0, 0, 0, 'h5a5, 'h111, 'h111, 1'b1, 1'b1, -1, -1);
    run_period("e_zero1", 0, 0, 0, 0, 'h5a5, 'h111, 'h111, 1'b0, 1'b1, -1, -1);
    run_period("e_zero2", 0, 0, 0, 0, 'h5a5, 'h111, 'h111, 1'b0, 1'b1, -1, 0);
    cyc("e_stop", 3'd0, '0, 1'b0, 1'b1);
    stop = 1'b0;

    // Reset mid-HIGH with a shadow word and a stop pending
    load_cfg(0, 1, 4, 1, 1, 'h800, 'h800, 'h800, 0);
    start = 1'b1;
    cyc("f_rise", 3'd2, 12'h800, 1'b0, 1'b1);
    start = 1'b0;
    cyc("f_high", 3'd3, 12'h800, 1'b0, 1'b1);
    cfg_valid = 1'b1;
    stop = 1'b1;
    cyc("f_high_push", 3'd3, 12'h800, 1'b0, 1'b0);
    cfg_valid = 1'b0;
    stop = 1'b0;
    rst = 1'b1;
    cyc("f_reset", 3'd0, '0, 1'b0, 1'b1);
    rst = 1'b0;
    cyc("f_idle", 3'd0, '0, 1'b0, 1'b1);
    load_cfg(0, 1, 4, 1, 1, 'h800, 'h800, 'h800, 0);
    run_period("f_run0", 1, 4, 1, 1, 'h800, 'h800, 'h800, 1'b1, 1'b1, -1, -1);
    run_period("f_run1", 1, 4, 1, 1, 'h800, 'h800, 'h800, 1'b0, 1'b1, -1, 6);
    cyc("f_stop", 3'd0, '0, 1'b0, 1'b1);
    stop = 1'b0;

`ifdef PULSE_SEQ_BURST_EN
    // Two bursts then DONE; start from DONE replays DELAY with a fresh count
    load_cfg(1, 1, 1, 0, 1, 'h100, 'h100, 'h000, 2);
    start = 1'b1;
    cyc("g_delay", 3'd1, '0, 1'b0, 1'b1);
    start = 1'b0;
    run_period("g_b1", 1, 1, 0, 1, 'h100, 'h100, 'h000, 1'b0, 1'b1, -1, -1);
    run_period("g_b2", 1, 1, 0, 1, 'h100, 'h100, 'h000, 1'b0, 1'b1, -1, -1);
    cyc("g_done", 3'd6, '0, 1'b0, 1'b1);
    cyc("g_done", 3'd6, '0, 1'b0, 1'b1);
    start = 1'b1;
    cyc("g_restart", 3'd1, '0, 1'b0, 1'b1);
    start = 1'b0;
    run_period("g_b3", 1, 1, 0, 1, 'h100, 'h100, 'h000, 1'b0, 1'b1, -1, -1);
    run_period("g_b4", 1, 1, 0, 1, 'h100, 'h100, 'h000, 1'b0, 1'b1, -1, -1);
    cyc("g_done2", 3'd6, '0, 1'b0, 1'b1);
`endif

    // Drain the scoreboard
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending entries, exp 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
